// File: rtl/rf_sb.sv
// ---------------------------------------------------------------------------
// rf_sb : flip-flop register file with a per-register busy scoreboard.
//
// Holds 2**AW registers of DW bits. One write port, NRD registered read
// ports (1-cycle latency) with optional write-to-read bypass, and an
// optional hardwired zero register. The scoreboard tracks registers whose
// producer has been issued but not yet written back, so decode can stall
// on RAW hazards.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   we         write enable
//   wr_addr    write address (AW bits)
//   wr_data    write data (DW bits)
//   rd_en      per-port read enable (NRD bits)
//   rd_addr    flattened read addresses, port i at [i*AW +: AW]
//   rd_data    flattened registered read data, port i at [i*DW +: DW]
//   rd_busy    registered busy flag of the address read on each port
//   iss_valid  issue strobe: mark iss_addr pending
//   iss_addr   destination register being issued
//   flush      synchronous clear of all busy bits (data untouched)
//   any_busy   OR of the registered busy vector
// ---------------------------------------------------------------------------
module rf_sb #(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic              any_busy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_ok;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_ok = we && !((ZERO_REG != 0) && (wr_addr == '0));

  // Scoreboard next state: flush wins over everything; otherwise the
  // writeback clears first so a same-cycle issue to the same register
  // leaves it pending for the new producer.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we)        busy_nxt[wr_addr]  = 1'b0;
      if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign any_busy = |busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic [DW-1:0] val;
    logic          bsy;
    logic [DW-1:0] data_q;
    logic          busy_q;

    assign addr = rd_addr[i*AW +: AW];
    assign hit  = (BYPASS != 0) && we && (wr_addr == addr);

    // With bypass the port sees the state as it will be after this edge
    // (forwarded data, post-update busy); without it, the pre-edge state.
    always_comb begin
      val = regs[addr];
      if (hit) val = wr_data;
      if ((ZERO_REG != 0) && (addr == '0)) val = '0;
      bsy = (BYPASS != 0) ? busy_nxt[addr] : busy[addr];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (rd_en[i]) begin
        data_q <= val;
        busy_q <= bsy;
      end
    end

    assign rd_data[i*DW +: DW] = data_q;
    assign rd_busy[i]          = busy_q;
  end

endmodule

// File: doc/rf_sb.md
Name: rf_sb

Overview:
- Parametrised flip-flop register file with a per-register busy scoreboard; successor to the processor's 16x16 latch-based register file.
- Provides NRD registered read ports with write-to-read bypass, one write port, and an optional hardwired zero register.
- Issue logic marks destination registers pending at dispatch; writeback clears them. Decode uses rd_busy to stall on RAW hazards.
- Sits between decode/issue and writeback in the pipeline.

Parameters:
- DW, 16, data width in bits.
- AW, 4, address width; depth is 2**AW registers.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a same-cycle write to the address being read is forwarded to the read result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rd_en  in  NRD  per-port read enable; bit i controls port i.
- rd_addr  in  NRD*AW  flattened read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*DW  flattened registered read data; port i at [i*DW +: DW].
- rd_busy  out  NRD  registered busy flag of the address read on port i.
- iss_valid  in  1  issue strobe: mark iss_addr pending.
- iss_addr  in  AW  destination register being issued.
- flush  in  1  synchronous clear of all busy bits; register contents are untouched.
- any_busy  out  1  combinational OR of all busy bits.

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-operation):
  - all registers, rd_data and rd_busy go to 0; all busy bits go to 0.
  - Held while rst=0. The first edge after release behaves normally.
- Write: at a rising edge with we=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, nothing happens.
- Read latency: exactly 1 cycle.
  - At an edge with rd_en[i]=1: rd_data[i] <= value of reg[rd_addr[i]] and rd_busy[i] <= busy[rd_addr[i]].
  - With rd_en[i]=0, port i holds its previous outputs.
- Bypass (BYPASS=1): at an edge where we=1, wr_addr equals rd_addr[i] and rd_en[i]=1, rd_data[i] <= wr_data.
  - If ZERO_REG=1 and the address is 0, the result is 0 instead.
  - rd_busy[i] takes the post-update busy value (rules below).
- No bypass (BYPASS=0): the read returns the pre-write register value, and rd_busy[i] returns the pre-update busy bit.
- Multiple ports reading the same address are independent and return identical results.
- Scoreboard update per edge, evaluated in this priority:
  - flush=1: all busy bits <= 0; iss_valid is ignored that cycle.
  - Otherwise, if we=1, busy[wr_addr] <= 0.
  - Then, if iss_valid=1, busy[iss_addr] <= 1. Issue overrides a writeback to the same register in the same cycle (new producer pending).
  - If ZERO_REG=1, busy[0] is constantly 0.
- Re-issue of an already-busy register leaves it busy; there is no counting.
- A write to a register that is not busy is legal and simply updates data.
- any_busy reflects the registered busy vector (the state after the last edge).
- Arithmetic: none. Addresses are always in range (depth = 2**AW), so no out-of-range case exists.
- Implementation target: a flop array with a generate loop over read ports; no latches.

Test Plan:
- Reset: drive rst=0 mid-stream after loading reg5=0xBEEF with reg5 busy -> immediately rd_data=0, rd_busy=0, any_busy=0. After release, a read of r5 returns 0x0000.
- Write/read latency: write r3=0x1234 at cycle N; read r3 on port 0 at cycle N+1 -> rd_data[0]=0x1234 one cycle later. With rd_en=0, the output holds its old value.
- Bypass: in the same cycle, write r7=0xA5A5 and read r7 on both ports with BYPASS=1 -> both ports show 0xA5A5 next cycle. Repeat with BYPASS=0 -> old value 0x0000.
- Zero register: write r0=0xFFFF with iss_valid, iss_addr=0 -> read r0 returns 0, rd_busy=0, any_busy=0.
- Scoreboard: issue r4 -> read shows busy=1. Same-cycle writeback r4 plus issue r4 -> busy stays 1. Writeback alone -> busy=0, data updated.
- Flush: issue r2, r9 and r15, then assert flush together with iss_valid on r6 -> all busy bits 0, any_busy=0 next cycle, and register data unchanged.
